seq_detect_param: RTL and testbench
===================================

// Module: seq_detect_param
// PURPOSE
//  Parametrised serial pattern detector: generalised successor of the fixed 1010 Mealy detector.
//  Pattern length and reset-value pattern are parameters. Pattern is runtime-loadable.
//  Overlap/non-overlap mode is runtime-selectable. Has an input-valid qualifier and a saturating match counter.
//  Sits on a 1-bit serial stream (e.g. deserialiser/UART bit path); z feeds framing/alarm logic.
// PARAMETERS
//  N        4        pattern length in bits, legal 2..32
//  PATTERN  4'b1010  pattern after reset, N bits, MSB = first bit received
//  CNT_W    8        width of match counter, legal 1..32
// PORTS
//  clk        in   1      rising-edge clock
//  reset      in   1      synchronous, active-high reset
//  x          in   1      serial data bit
//  x_valid    in   1      x is sampled only when 1; idle cycles are ignored (no state change)
//  overlap_en in   1      1 = overlapping detection, 0 = non-overlapping
//  pat_load   in   1      load pat_in as new pattern this cycle
//  pat_in     in   N      new pattern, MSB first
//  cnt_clr    in   1      clear match counter
//  z          out  1      Mealy match: combinational, = x_valid & match on current x
//  z_q        out  1      z registered (one-cycle-delayed pulse)
//  match_cnt  out  CNT_W  saturating count of matches
// BEHAVIOUR
//  Reset (sync, highest priority): pat_r<=PATTERN; hist<=0; fill<=0; z_q<=0; match_cnt<=0; z=0.
//  State: hist[N-2:0] holds the last N-1 accepted bits (newest bit in LSB).
//         fill holds the number of valid bits in hist, 0..N-1, saturating at N-1.
//  Candidate word cand = {hist[N-2:0], x}.
//  Match: hit = x_valid & (fill==N-1) & (cand==pat_r). Output z = hit. Latency 0 (Mealy).
//  On accepted bit (x_valid=1, no pat_load):
//    hit & !overlap_en: hist<=0 and fill<=0. Restart from scratch, equivalent to returning to S0.
//    otherwise: hist<=cand[N-2:0] and fill<=min(fill+1,N-1).
//      With overlap, a suffix of a match can start the next match (e.g. 1010 matches on "1010","10").
//  x_valid=0: hist, fill and z_q=0 pulse behaviour only. No shift, and z=0.
//  z_q <= hit every cycle. It is a 1-cycle pulse per match; back-to-back matches give consecutive 1s.
//  match_cnt:
//    cnt_clr -> 0.
//    else on hit -> match_cnt+1, saturating at all-ones (no wrap).
//    cnt_clr and hit in the same cycle -> result is 0 (clear wins).
//  pat_load:
//    pat_r<=pat_in, hist<=0, fill<=0.
//    x in the same cycle is discarded and z is forced 0, even if x_valid=1.
//    match_cnt is unaffected.
//  overlap_en change mid-stream takes effect on the current cycle's hit. No history flush.
//  Reset mid-stream: the next accepted bit is the first bit of a fresh window. No match for N-1 accepted bits.
//  fill gating ensures no false match on reset-zero history (e.g. pattern 0000 needs 4 real zeros).
// STRUCTURE
//  Single always-ff for pat_r/hist/fill/z_q/match_cnt plus a combinational hit/z block.
//  Shared package seq_det_pkg:
//    localparams OVL_OFF=1'b0, OVL_ON=1'b1.
//    function for the saturating increment.
//  One natural sub-module: sat_counter #(W) (clk, reset, clr, inc, q). It is reused for match_cnt.
//  Fill counter width $clog2(N).
// TESTING
//  1 Defaults, overlap_en=0, x_valid=1, stream 1010_1010_10
//    -> z at bits 4 and 8 only; z_q one cycle later; match_cnt=2.
//  2 Defaults, overlap_en=1, same stream
//    -> z at bits 4,6,8,10; match_cnt=4; z_q shows the pulses delayed by one cycle.
//  3 Stream 1,0,(x_valid=0 x3, x=1),1,0 with overlap_en=0
//    -> single hit on last bit; idle cycles change nothing.
//  4 pat_load pat_in=4'b0000 mid-stream, then 000 -> no z; one more 0 -> z=1.
//    With overlap_en=1, continued zeros -> z every cycle.
//  5 CNT_W=2, overlap on 101010101010 -> match_cnt saturates at 3.
//    cnt_clr coincident with a hit -> match_cnt=0.
//  6 reset asserted after 101 of 1010 -> next 0 gives no hit; a full 1010 is needed for z=1.
//    All outputs are 0 during reset.

Source files
------------

// File: rtl/seq_det_pkg.sv
// Shared definitions for the serial pattern detector.
//   OVL_OFF / OVL_ON : encodings of the overlap_en input
//   sat_inc()        : increment that holds at a caller-supplied ceiling
package seq_det_pkg;

  localparam logic OVL_OFF = 1'b0;
  localparam logic OVL_ON  = 1'b1;

  // Widths up to 32 bits are handled by zero-extending into 32 bits.
  // The caller then truncates the result back to its own width.
  function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] max);
    return (v >= max) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous, active-high; returns q to zero
//   clr   : synchronous clear; takes priority over inc
//   inc   : count by one; the counter holds once it reaches all-ones
//   q     : current count, W bits
module sat_counter
  import seq_det_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] q
);

  localparam logic [W-1:0] Q_MAX = '1;

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (inc) begin
      q <= W'(sat_inc(32'(q), 32'(Q_MAX)));
    end
  end

endmodule

// File: rtl/seq_detect_param.sv
// Parametrised serial pattern detector (Mealy).
// The pattern is loadable at runtime. Overlap mode is selectable at runtime.
// Ports:
//   clk        : rising-edge clock
//   reset      : synchronous, active-high
//   x, x_valid : serial bit and its qualifier (idle cycles leave state untouched)
//   overlap_en : 1 = a match suffix may start the next match, 0 = restart after a match
//   pat_load   : load pat_in this cycle; flushes history and discards this cycle's x
//   pat_in     : new pattern, MSB is the first bit received
//   cnt_clr    : clear match_cnt (wins over a coincident match)
//   z          : combinational match on the current bit
//   z_q        : z delayed by one clock
//   match_cnt  : saturating number of matches
module seq_detect_param
  import seq_det_pkg::*;
#(
  parameter int             N       = 4,
  parameter logic [N-1:0]   PATTERN = 4'b1010,
  parameter int             CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             x,
  input  logic             x_valid,
  input  logic             overlap_en,
  input  logic             pat_load,
  input  logic [N-1:0]     pat_in,
  input  logic             cnt_clr,
  output logic             z,
  output logic             z_q,
  output logic [CNT_W-1:0] match_cnt
);

  localparam int                FILL_W    = $clog2(N);
  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(N - 1);

  logic [N-1:0]      pat_r;
  logic [N-2:0]      hist;
  logic [FILL_W-1:0] fill;
  logic [N-1:0]      cand;
  logic              hit;

  // fill gating stops the zeroed history from matching patterns such as all-zeros.
  // A pending pattern load or reset suppresses the match on this cycle's bit.
  always_comb begin
    cand = {hist, x};
    hit  = x_valid & ~pat_load & ~reset & (fill == FILL_FULL) & (cand == pat_r);
    z    = hit;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pat_r <= PATTERN;
      hist  <= '0;
      fill  <= '0;
      z_q   <= 1'b0;
    end else begin
      z_q <= hit;
      if (pat_load) begin
        pat_r <= pat_in;
        hist  <= '0;
        fill  <= '0;
      end else if (x_valid) begin
        if (hit && (overlap_en == OVL_OFF)) begin
          hist <= '0;
          fill <= '0;
        end else begin
          hist <= cand[N-2:0];
          if (fill != FILL_FULL) begin
            fill <= fill + FILL_W'(1);
          end
        end
      end
    end
  end

  sat_counter #(.W(CNT_W)) u_match_cnt (
    .clk   (clk),
    .reset (reset),
    .clr   (cnt_clr),
    .inc   (hit),
    .q     (match_cnt)
  );

endmodule

// File: tb/tb_seq_detect_param.sv
// Directed bench for seq_detect_param.
// Instance a uses the default parameters. Instance b uses CNT_W=2 to exercise saturation.
// A queue-based window model is checked on every cycle.
// Literal expectations pin down the model.
module tb_seq_detect_param;

  logic       clk = 1'b0;
  logic       reset, x, x_valid, overlap_en, pat_load, cnt_clr;
  logic [3:0] pat_in;
  logic       z_a, zq_a, z_b, zq_b;
  logic [7:0] cnt_a;
  logic [1:0] cnt_b;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  seq_detect_param dut_a (
    .clk(clk), .reset(reset), .x(x), .x_valid(x_valid), .overlap_en(overlap_en),
    .pat_load(pat_load), .pat_in(pat_in), .cnt_clr(cnt_clr),
    .z(z_a), .z_q(zq_a), .match_cnt(cnt_a)
  );

  seq_detect_param #(.CNT_W(2)) dut_b (
    .clk(clk), .reset(reset), .x(x), .x_valid(x_valid), .overlap_en(overlap_en),
    .pat_load(pat_load), .pat_in(pat_in), .cnt_clr(cnt_clr),
    .z(z_b), .z_q(zq_b), .match_cnt(cnt_b)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the accepted bits since the last restart, keeping at most the last three.
  bit         win[$];
  logic [3:0] m_pat = 4'b1010;
  bit         m_zq = 1'b0;
  int         m_cnt_a = 0;
  int         m_cnt_b = 0;
  bit         started = 1'b0;

  function automatic bit m_hit();
    logic [3:0] w;
    if (reset || pat_load || !x_valid || win.size() < 3) return 1'b0;
    w = {win[0], win[1], win[2], x};
    return w == m_pat;
  endfunction

  always @(posedge clk) begin
    bit h;
    h = m_hit();
    if (reset) begin
      win.delete();
      m_pat   = 4'b1010;
      m_zq    = 1'b0;
      m_cnt_a = 0;
      m_cnt_b = 0;
      started = 1'b1;
    end else begin
      m_zq = h;
      if (cnt_clr) begin
        m_cnt_a = 0;
        m_cnt_b = 0;
      end else if (h) begin
        if (m_cnt_a < 255) m_cnt_a++;
        if (m_cnt_b < 3)   m_cnt_b++;
      end
      if (pat_load) begin
        m_pat = pat_in;
        win.delete();
      end else if (x_valid) begin
        if (h && !overlap_en) begin
          win.delete();
        end else begin
          win.push_back(x);
          if (win.size() > 3) void'(win.pop_front());
        end
      end
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("model_z_a",   32'(z_a),   32'(m_hit()));
      chk("model_z_b",   32'(z_b),   32'(m_hit()));
      chk("model_zq_a",  32'(zq_a),  32'(m_zq));
      chk("model_zq_b",  32'(zq_b),  32'(m_zq));
      chk("model_cnt_a", 32'(cnt_a), 32'(m_cnt_a));
      chk("model_cnt_b", 32'(cnt_b), 32'(m_cnt_b));
    end
  end

  // Inputs change 1 after the rising edge; the literal z check is made at the falling edge.
  task automatic cyc(input logic ez);
    #4;
    chk("lit_z", 32'(z_a), 32'(ez));
    @(posedge clk);
    #1;
  endtask

  task automatic bit_in(input logic b, input logic ez);
    x       = b;
    x_valid = 1'b1;
    cyc(ez);
  endtask

  task automatic idle();
    x       = 1'b1;
    x_valid = 1'b0;
    cyc(1'b0);
  endtask

  task automatic do_reset();
    reset   = 1'b1;
    x_valid = 1'b0;
    cyc(1'b0);
    reset   = 1'b0;
  endtask

  initial begin
    logic [9:0] s, e1, e2;
    s  = 10'b1010101010;
    e1 = 10'b0001000100;
    e2 = 10'b0001010101;

    reset = 1'b1; x = 1'b0; x_valid = 1'b0; overlap_en = 1'b0;
    pat_load = 1'b0; pat_in = 4'b0000; cnt_clr = 1'b0;
    @(posedge clk);
    #1;
    cyc(1'b0);
    chk("rst_zq", 32'(zq_a), 32'd0);
    chk("rst_cnt", 32'(cnt_a), 32'd0);
    reset = 1'b0;

    // Non-overlapping detection on 1010101010.
    overlap_en = 1'b0;
    for (int i = 0; i < 10; i++) begin
      bit_in(s[9-i], e1[9-i]);
      chk("t1_zq", 32'(zq_a), 32'(e1[9-i]));
    end
    chk("t1_cnt", 32'(cnt_a), 32'd2);

    // Overlapping detection on the same stream; the 2-bit counter saturates.
    do_reset();
    overlap_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      bit_in(s[9-i], e2[9-i]);
      chk("t2_zq", 32'(zq_a), 32'(e2[9-i]));
    end
    chk("t2_cnt_a", 32'(cnt_a), 32'd4);
    chk("t2_cnt_b", 32'(cnt_b), 32'd3);

    // Idle cycles are ignored.
    do_reset();
    overlap_en = 1'b0;
    bit_in(1'b1, 1'b0);
    bit_in(1'b0, 1'b0);
    idle(); idle(); idle();
    bit_in(1'b1, 1'b0);
    bit_in(1'b0, 1'b1);
    chk("t3_cnt", 32'(cnt_a), 32'd1);

    // Load 0000 mid-stream; the bit in the load cycle is discarded.
    bit_in(1'b1, 1'b0);
    bit_in(1'b1, 1'b0);
    pat_load = 1'b1; pat_in = 4'b0000; x = 1'b0; x_valid = 1'b1;
    cyc(1'b0);
    pat_load = 1'b0;
    bit_in(1'b0, 1'b0); bit_in(1'b0, 1'b0); bit_in(1'b0, 1'b0);
    bit_in(1'b0, 1'b1);
    chk("t4_cnt", 32'(cnt_a), 32'd2);
    overlap_en = 1'b1;
    bit_in(1'b0, 1'b0); bit_in(1'b0, 1'b0); bit_in(1'b0, 1'b0);
    bit_in(1'b0, 1'b1); bit_in(1'b0, 1'b1); bit_in(1'b0, 1'b1);
    chk("t4_cnt_a", 32'(cnt_a), 32'd5);
    chk("t4_cnt_b", 32'(cnt_b), 32'd3);

    // A clear coincident with a hit leaves the counter at zero.
    cnt_clr = 1'b1;
    bit_in(1'b0, 1'b1);
    cnt_clr = 1'b0;
    chk("t5_clr_a", 32'(cnt_a), 32'd0);
    chk("t5_clr_b", 32'(cnt_b), 32'd0);
    bit_in(1'b0, 1'b1);
    chk("t5_cnt", 32'(cnt_a), 32'd1);
    // A load cycle suppresses z even though the history would match.
    pat_load = 1'b1; pat_in = 4'b0000; x = 1'b0; x_valid = 1'b1;
    cyc(1'b0);
    pat_load = 1'b0;
    chk("t5_load_cnt", 32'(cnt_a), 32'd1);

    // Reset mid-pattern: the history is dropped and a full 1010 is needed again.
    do_reset();
    overlap_en = 1'b0;
    bit_in(1'b1, 1'b0); bit_in(1'b0, 1'b0); bit_in(1'b1, 1'b0);
    reset = 1'b1; x = 1'b0; x_valid = 1'b1;
    cyc(1'b0);
    chk("t6_rst_zq", 32'(zq_a), 32'd0);
    chk("t6_rst_cnt", 32'(cnt_a), 32'd0);
    reset = 1'b0;
    bit_in(1'b0, 1'b0);
    bit_in(1'b1, 1'b0);
    bit_in(1'b0, 1'b0);
    bit_in(1'b1, 1'b0);
    bit_in(1'b0, 1'b1);
    chk("t6_cnt", 32'(cnt_a), 32'd1);

    x_valid = 1'b0;
    cyc(1'b0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
